weight_stream_controller: RTL and testbench

Sequences a fixed-latency weight ROM (e.g. an fc1_weight-style parameter memory) into a valid/ready weight stream for a linear layer.
- Replaces a free-running address counter with credit-based read issue, an output skid FIFO and start/done control.
- Streams the full tensor num_repeats times per start and marks the last beat of each pass.
- Sits between the parameter ROM and the linear datapath's weight input.

---
 rtl/weight_stream_pkg.sv | 15 +
 rtl/weight_stream_controller_if.sv | 24 ++
 rtl/weight_stream_fifo.sv | 55 +++++
 rtl/weight_stream_controller.sv | 140 ++++++++++++++
 tb/tb_weight_stream_controller.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_stream_pkg.sv
// Shared types and helpers for the weight stream controller and its FIFO.
package weight_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Bit offset of weight lane `lane` inside a packed ROM word.
    function automatic int lane_base(input int lane, input int prec);
        return lane * prec;
    endfunction

endpackage

// File: rtl/weight_stream_controller_if.sv
// Valid/ready weight beat stream: unpacked lanes plus end-of-pass marker.
interface weight_stream_controller_if #(
    parameter int WEIGHT_PRECISION_0       = 16,
    parameter int WEIGHT_PARALLELISM_DIM_0 = 1
);
    logic [WEIGHT_PRECISION_0-1:0] data_out [WEIGHT_PARALLELISM_DIM_0];
    logic                          data_out_valid;
    logic                          data_out_ready;
    logic                          data_out_last;

    modport master (
        output data_out,
        output data_out_valid,
        output data_out_last,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  data_out_last,
        output data_out_ready
    );
endinterface

// File: rtl/weight_stream_fifo.sv
// Synchronous FIFO, head presented straight from storage (no input bypass).
// Push and pop may coincide at any occupancy, including full.
module weight_stream_fifo
    import weight_stream_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
endmodule

// File: rtl/weight_stream_controller.sv
// Streams a fixed-latency weight ROM num_repeats times per start as valid/ready beats.
// First beat ROM_LATENCY+1 edges after start; reads are credit-limited so backpressure never overflows the FIFO.
module weight_stream_controller
    import weight_stream_pkg::*;
#(
    parameter int WEIGHT_PRECISION_0       = 16,
    parameter int WEIGHT_PARALLELISM_DIM_0 = 1,
    parameter int OUT_DEPTH                = 32,
    parameter int ROM_LATENCY              = 2,
    parameter int FIFO_DEPTH               = 4,
    parameter int REPEAT_WIDTH             = 8,
    parameter int ADDR_WIDTH               = $clog2(OUT_DEPTH + 1)
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   start,
    input  logic [REPEAT_WIDTH-1:0]                                num_repeats,
    output logic                                                   busy,
    output logic                                                   done,
    output logic [ADDR_WIDTH-1:0]                                  rom_addr,
    output logic                                                   rom_ce,
    input  logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM_DIM_0-1:0] rom_q,
    weight_stream_controller_if.master                             dout
);
    localparam int W  = WEIGHT_PRECISION_0 * WEIGHT_PARALLELISM_DIM_0;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(OUT_DEPTH - 1);
    localparam logic [CW:0]           CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] RUN   = 2'(ST_RUN);
    localparam logic [1:0] DRAIN = 2'(ST_DRAIN);

    logic [1:0]              state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [REPEAT_WIDTH-1:0] pass_cnt;
    logic [REPEAT_WIDTH-1:0] reps;
    logic [ROM_LATENCY-1:0]  sr_vld;
    logic [ROM_LATENCY-1:0]  sr_last;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             credit_used;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [W:0]              fifo_head;
    logic                    issue;
    logic                    emerge;
    logic                    pop;
    logic                    addr_wrap;
    logic                    final_issue;

    // Credits count both reads still inside the ROM pipe and beats already buffered.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign issue       = (state == RUN) && (credit_used < CREDIT_MAX) && !fifo_full;
    assign addr_wrap   = (addr == LAST_ADDR);
    assign final_issue = issue && addr_wrap && (pass_cnt == reps - REPEAT_WIDTH'(1));
    assign emerge      = sr_vld[ROM_LATENCY-1];
    assign pop         = dout.data_out_valid && dout.data_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            pass_cnt <= '0;
            reps     <= '0;
            done     <= 1'b0;
            sr_vld   <= '0;
            sr_last  <= '0;
            inflight <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_repeats != '0) begin
                            state    <= RUN;
                            reps     <= num_repeats;
                            addr     <= '0;
                            pass_cnt <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr <= addr_wrap ? '0 : addr + 1'b1;
                        if (addr_wrap) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                    end
                    if (final_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (inflight == '0 && fifo_empty) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            sr_vld[0]  <= issue;
            sr_last[0] <= issue && addr_wrap;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                sr_vld[i]  <= sr_vld[i-1];
                sr_last[i] <= sr_last[i-1];
            end
            inflight <= inflight + CW'(issue) - CW'(emerge);
        end
    end

    weight_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (emerge),
        .push_dat ({sr_last[ROM_LATENCY-1], rom_q}),
        .pop      (pop),
        .pop_dat  (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    for (genvar j = 0; j < WEIGHT_PARALLELISM_DIM_0; j++) begin : g_lane
        assign dout.data_out[j] =
            fifo_head[lane_base(j, WEIGHT_PRECISION_0) +: WEIGHT_PRECISION_0];
    end

    assign dout.data_out_valid = !fifo_empty;
    assign dout.data_out_last  = !fifo_empty && fifo_head[W];
    assign busy                = (state != IDLE);
    assign rom_addr            = addr;
    assign rom_ce              = 1'b1;
endmodule

// File: tb/tb_weight_stream_controller.sv
// Randomized bench for weight_stream_controller against a queue-based beat model.
module tb_weight_stream_controller;
    localparam int WP   = 16;
    localparam int WPAR = 2;
    localparam int OD   = 8;
    localparam int RL   = 2;
    localparam int FD   = 4;
    localparam int RW   = 8;
    localparam int AW   = $clog2(OD + 1);
    localparam int W    = WP * WPAR;

    typedef struct packed {
        logic [W-1:0] w;
        logic         last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [RW-1:0] num_repeats = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic          rom_ce;
    logic [W-1:0]  rom_q = '0;
    logic [AW-1:0] rom_a1 = '0;

    int    checks = 0;
    int    errors = 0;
    int    beats = 0;
    int    done_cnt = 0;
    int    issued = 0;
    int    popped = 0;
    int    ready_mode = 0;
    bit    active = 0;
    beat_t exp_q[$];

    logic [AW-1:0] prev_addr = '0;
    bit            hold_prev = 0;
    logic [W:0]    prev_beat = '0;

    weight_stream_controller_if #(
        .WEIGHT_PRECISION_0       (WP),
        .WEIGHT_PARALLELISM_DIM_0 (WPAR)
    ) dout ();

    weight_stream_controller #(
        .WEIGHT_PRECISION_0       (WP),
        .WEIGHT_PARALLELISM_DIM_0 (WPAR),
        .OUT_DEPTH                (OD),
        .ROM_LATENCY              (RL),
        .FIFO_DEPTH               (FD),
        .REPEAT_WIDTH             (RW),
        .ADDR_WIDTH               (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_repeats (num_repeats),
        .busy        (busy),
        .done        (done),
        .rom_addr    (rom_addr),
        .rom_ce      (rom_ce),
        .rom_q       (rom_q),
        .dout        (dout)
    );

    always #5 clk = ~clk;

    // Lane 0 carries k+0x10; lane 1 carries a distinct pattern to expose lane mix-ups.
    function automatic logic [W-1:0] rom_word(input int k);
        logic [WP-1:0] lo;
        logic [WP-1:0] hi;
        lo = WP'(k + 16'h10);
        hi = WP'(k * 37 + 16'h5A00);
        return {hi, lo};
    endfunction

    // Two-edge ROM: address register then output register.
    always @(posedge clk) begin
        if (rom_ce) begin
            rom_a1 <= rom_addr;
            rom_q  <= rom_word(int'(rom_a1));
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] beat_word();
        logic [W-1:0] v;
        for (int j = 0; j < WPAR; j++) begin
            v[j*WP +: WP] = dout.data_out[j];
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            issued    = 0;
            popped    = 0;
            hold_prev = 0;
            prev_addr = '0;
        end else begin
            if (rom_addr != prev_addr) begin
                chk("addr_step", 64'(rom_addr), 64'((int'(prev_addr) + 1) % OD));
                issued++;
            end
            chk("credit", 64'(issued - popped <= FD), 64'd1);
            if (hold_prev) begin
                chk("hold_valid", 64'(dout.data_out_valid), 64'd1);
                chk("hold_beat", 64'({dout.data_out_last, beat_word()}), 64'(prev_beat));
            end
            if (dout.data_out_valid && dout.data_out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(beat_word()), 64'(e.w));
                    chk("beat_last", 64'(dout.data_out_last), 64'(e.last));
                end
                popped++;
                beats++;
            end
            if (done) begin
                chk("done_after_last", 64'(exp_q.size()), 64'd0);
                done_cnt++;
                active = 0;
            end
            hold_prev = dout.data_out_valid && !dout.data_out_ready;
            prev_beat = {dout.data_out_last, beat_word()};
            prev_addr = rom_addr;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) dout.data_out_ready = 1'b1;
            else if (ready_mode == 1) dout.data_out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        beats    = 0;
        done_cnt = 0;
        issued   = 0;
        popped   = 0;
    endtask

    // The model accepts a start only when it believes no run is active.
    task automatic start_run(input int n);
        start       = 1'b1;
        num_repeats = RW'(n);
        chk("busy_at_start", 64'(busy), 64'(active));
        if (!active && n != 0) begin
            active = 1;
            for (int r = 0; r < n; r++) begin
                for (int k = 0; k < OD; k++) begin
                    exp_q.push_back('{w: rom_word(k), last: (k == OD - 1)});
                end
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_timeout", 64'(done_cnt != 0), 64'd1);
        repeat (3) tick();
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n = 0;
        while (beats < target && n < budget) begin
            tick();
            n++;
        end
        chk("beats_timeout", 64'(beats >= target), 64'd1);
    endtask

    initial begin
        dout.data_out_ready = 1'b1;
        ready_mode = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(dout.data_out_valid), 64'd0);
        chk("rst_last", 64'(dout.data_out_last), 64'd0);
        chk("rst_addr", 64'(rom_addr), 64'd0);
        chk("rst_ce", 64'(rom_ce), 64'd1);
        repeat (5) tick();
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_valid", 64'(dout.data_out_valid), 64'd0);
        chk("idle_addr", 64'(rom_addr), 64'd0);

        // Single pass with latency and address sequence checks.
        clear_counts();
        start_run(1);
        chk("lat_addr0", 64'(rom_addr), 64'd0);
        chk("lat_valid0", 64'(dout.data_out_valid), 64'd0);
        for (int c = 1; c <= 2; c++) begin
            tick();
            chk("lat_addr", 64'(rom_addr), 64'(c));
            chk("lat_valid", 64'(dout.data_out_valid), 64'd0);
        end
        tick();
        chk("lat_valid3", 64'(dout.data_out_valid), 64'd1);
        chk("lat_addr3", 64'(rom_addr), 64'd3);
        wait_done(100);
        chk("single_beats", 64'(beats), 64'(OD));
        chk("single_done", 64'(done_cnt), 64'd1);
        chk("single_busy", 64'(busy), 64'd0);

        // Backpressure: ready low for 5 cycles after beat 2.
        clear_counts();
        start_run(1);
        ready_mode = 2;
        wait_beats(2, 50);
        dout.data_out_ready = 1'b0;
        repeat (5) tick();
        chk("stall_outstanding", 64'(issued - popped), 64'(FD));
        dout.data_out_ready = 1'b1;
        ready_mode = 0;
        wait_done(100);
        chk("bp_beats", 64'(beats), 64'(OD));
        chk("bp_done", 64'(done_cnt), 64'd1);

        // Three passes under random ready.
        clear_counts();
        ready_mode = 1;
        start_run(3);
        wait_done(400);
        chk("rep_beats", 64'(beats), 64'(3 * OD));
        chk("rep_done", 64'(done_cnt), 64'd1);

        // Zero repeats: immediate done, nothing issued.
        clear_counts();
        ready_mode = 0;
        start_run(0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        tick();
        chk("zero_done_pulse", 64'(done), 64'd0);
        repeat (10) tick();
        chk("zero_issued", 64'(issued), 64'd0);
        chk("zero_beats", 64'(beats), 64'd0);
        chk("zero_done_cnt", 64'(done_cnt), 64'd1);

        // Start while busy is ignored.
        clear_counts();
        start_run(2);
        repeat (4) tick();
        start_run(5);
        wait_done(200);
        chk("busy_start_beats", 64'(beats), 64'(2 * OD));
        chk("busy_start_done", 64'(done_cnt), 64'd1);

        // Reset mid-run, then a clean restart.
        ready_mode = 1;
        clear_counts();
        start_run(2);
        wait_beats(4, 100);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        active = 0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_addr", 64'(rom_addr), 64'd0);
        repeat (4) tick();
        chk("midrst_valid", 64'(dout.data_out_valid), 64'd0);
        clear_counts();
        start_run(1);
        wait_done(200);
        chk("midrst_beats", 64'(beats), 64'(OD));
        chk("midrst_done", 64'(done_cnt), 64'd1);

        // Random runs with occasional ignored starts.
        for (int it = 0; it < 6; it++) begin
            int n;
            n = $urandom_range(1, 4);
            ready_mode = $urandom_range(0, 1);
            clear_counts();
            start_run(n);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 5)) tick();
                start_run($urandom_range(0, 7));
            end
            wait_done(200 * n);
            chk("rand_beats", 64'(beats), 64'(n * OD));
            chk("rand_done", 64'(done_cnt), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
